upscaler_window_buffer: RTL and testbench

//  Stage directly upstream of resolution_upscaler_cell. Accepts a raster-order RGB888 pixel

---
 rtl/upscaler_window_buffer_if.sv | 24 ++
 rtl/upscaler_window_buffer.sv | 119 +++++++++++
 tb/tb_upscaler_window_buffer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/upscaler_window_buffer_if.sv
// Stream bundle between a raster RGB888 pixel source, the 2x2 window buffer and the upscaler cell.
// Handshake: a beat moves on a rising edge only when valid and ready are both high; valid-side data stays stable while valid & !ready.
interface upscaler_window_buffer_if;
    logic [23:0] s_pixel;
    logic        s_valid;
    logic        s_ready;
    logic        s_sof;
    logic [95:0] m_win;
    logic        m_valid;
    logic        m_ready;
    logic        m_sof;
    logic        m_eol;
    logic        sof_err;

    modport slave (
        input  s_pixel, s_valid, s_sof, m_ready,
        output s_ready, m_win, m_valid, m_sof, m_eol, sof_err
    );

    modport master (
        output s_pixel, s_valid, s_sof, m_ready,
        input  s_ready, m_win, m_valid, m_sof, m_eol, sof_err
    );
endinterface

// File: rtl/upscaler_window_buffer.sv
// Buffers one source line and packs non-overlapping 2x2 windows from a raster RGB888 stream
// into the [row][col][chan] layout expected by resolution_upscaler_cell.
module upscaler_window_buffer #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic                     clk,
    input  logic                     rst_n,
    upscaler_window_buffer_if.slave  bus
);
    localparam int CW = $clog2(H_ACTIVE);
    localparam int RW = $clog2(V_ACTIVE);
    localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_ACTIVE - 1);

    logic [CW-1:0] col, eff_col;
    logic [RW-1:0] row, eff_row;
    logic          at_origin;
    logic          s_ready_int;
    logic          s_acc;
    logic          win_load;

    logic [23:0]   line_buf [H_ACTIVE];
    logic [23:0]   buf_rd;
    logic [23:0]   tl_q;
    logic [23:0]   bl_q;

    logic [95:0]   win_q;
    logic          valid_q;
    logic          sof_q;
    logic          eol_q;
    logic          err_q;

    assign at_origin = (col == '0) && (row == '0);

    // Only the bottom-right pixel produces a window, so only it must wait for a stalled output.
    assign s_ready_int = !(row[0] && col[0] && valid_q && !bus.m_ready);
    assign s_acc       = bus.s_valid && s_ready_int;

    // A start-of-frame pixel is placed at the origin regardless of where the counters are.
    always_comb begin
        eff_col = col;
        eff_row = row;
        if (bus.s_sof) begin
            eff_col = '0;
            eff_row = '0;
        end
    end

    assign buf_rd   = line_buf[eff_col];
    assign win_load = s_acc && eff_row[0] && eff_col[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (s_acc) begin
            if (eff_col == COL_LAST) begin
                col <= '0;
                row <= (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
            end else begin
                col <= eff_col + 1'b1;
                row <= eff_row;
            end
        end
    end

    // Line storage carries no reset so it can map onto RAM; reads always follow a write in the same frame.
    always_ff @(posedge clk) begin
        if (s_acc && !eff_row[0]) begin
            line_buf[eff_col] <= bus.s_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tl_q <= '0;
            bl_q <= '0;
        end else if (s_acc && eff_row[0] && !eff_col[0]) begin
            bl_q <= bus.s_pixel;
            tl_q <= buf_rd;
        end else if (s_acc && bus.s_sof && !at_origin) begin
            tl_q <= '0;
            bl_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else if (win_load) begin
            win_q   <= {tl_q, buf_rd, bl_q, bus.s_pixel};
            valid_q <= 1'b1;
            sof_q   <= (eff_row == RW'(1)) && (eff_col == CW'(1));
            eol_q   <= (eff_col == COL_LAST);
        end else if (valid_q && bus.m_ready) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= s_acc && bus.s_sof && !at_origin;
        end
    end

    assign bus.s_ready = s_ready_int;
    assign bus.m_win   = win_q;
    assign bus.m_valid = valid_q;
    assign bus.m_sof   = sof_q;
    assign bus.m_eol   = eol_q;
    assign bus.sof_err = err_q;

endmodule

// File: tb/tb_upscaler_window_buffer.sv
// Directed bench for upscaler_window_buffer on a 4x4 frame where p(r,c) = r*16+c in every channel.
module tb_upscaler_window_buffer;
    localparam int H = 4;
    localparam int V = 4;
    localparam int W = 98;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    upscaler_window_buffer_if ifc();

    upscaler_window_buffer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int  total = 0;
    int  bad   = 0;
    bit  rand_mode = 1'b0;

    always @(posedge clk) begin
        if (rst_n && ifc.m_valid && ifc.m_ready)
            got_q.push_back({ifc.m_sof, ifc.m_eol, ifc.m_win});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] px(input int r, input int c);
        logic [7:0] b;
        b = 8'(r * 16 + c);
        return {b, b, b};
    endfunction

    task automatic push_frame();
        for (int br = 0; br < V / 2; br++)
            for (int bc = 0; bc < H / 2; bc++)
                exp_q.push_back({(br == 0 && bc == 0), (bc == H / 2 - 1),
                                 px(2 * br, 2 * bc), px(2 * br, 2 * bc + 1),
                                 px(2 * br + 1, 2 * bc), px(2 * br + 1, 2 * bc + 1)});
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send_raw(input logic [23:0] pix, input bit sof);
        int n;
        @(negedge clk);
        if (rand_mode) begin
            ifc.m_ready = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) begin
                ifc.s_valid = 1'b0;
                @(negedge clk);
                ifc.m_ready = 1'($urandom_range(0, 1));
            end
        end
        ifc.s_pixel = pix;
        ifc.s_valid = 1'b1;
        ifc.s_sof   = sof;
        n = 0;
        #1;
        while (!ifc.s_ready && n < 200) begin
            @(negedge clk);
            if (rand_mode) ifc.m_ready = 1'($urandom_range(0, 1));
            #1;
            n++;
        end
        if (n >= 200) begin
            chk("accept_timeout", W'(ifc.s_ready), W'(1));
            ifc.s_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_px(input int r, input int c, input bit sof);
        send_raw(px(r, c), sof);
    endtask

    task automatic send_frame();
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                send_px(r, c, (r == 0 && c == 0));
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        ifc.s_valid = 1'b0;
        ifc.s_sof   = 1'b0;
        rand_mode   = 1'b0;
        ifc.m_ready = 1'b1;
        n = 0;
        #1;
        while (ifc.m_valid && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("drain_timeout", W'(ifc.m_valid), W'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_stream(input string tag);
        int i;
        chk($sformatf("%s_count", tag), W'(got_q.size()), W'(exp_q.size()));
        i = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            chk($sformatf("%s_win%0d", tag, i), got_q.pop_front(), exp_q.pop_front());
            i++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        ifc.s_pixel = '0;
        ifc.s_valid = 1'b0;
        ifc.s_sof   = 1'b0;
        ifc.m_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_m_valid", W'(ifc.m_valid), W'(0));
        chk("rst_m_win",   W'(ifc.m_win),   W'(0));
        chk("rst_s_ready", W'(ifc.s_ready), W'(1));
        chk("rst_sof_err", W'(ifc.sof_err), W'(0));
        chk("rst_m_sof",   W'({ifc.m_sof, ifc.m_eol}), W'(0));
        rst_n = 1'b1;

        // Test 1: reset mid-stream with a window pending, then a clean frame.
        ifc.m_ready = 1'b0;
        for (int c = 0; c < H; c++) send_px(0, c, (c == 0));
        send_px(1, 0, 1'b0);
        send_px(1, 1, 1'b0);
        chk("t1_pending_valid", W'(ifc.m_valid), W'(1));
        @(negedge clk);
        ifc.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t1_rst_m_valid", W'(ifc.m_valid), W'(0));
        chk("t1_rst_m_win",   W'(ifc.m_win),   W'(0));
        chk("t1_rst_s_ready", W'(ifc.s_ready), W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        ifc.m_ready = 1'b1;
        got_q.delete();
        push_frame();
        send_frame();
        drain();
        check_stream("t1");

        // Test 2: single frame, always-ready, with hand-computed windows.
        send_px(0, 0, 1'b1);
        chk("t2_sof_origin_no_err", W'(ifc.sof_err), W'(0));
        for (int c = 1; c < H; c++) send_px(0, c, 1'b0);
        for (int r = 1; r < V; r++)
            for (int c = 0; c < H; c++) send_px(r, c, 1'b0);
        drain();
        chk("t2_first", got_q[0], {2'b10, 96'h000000_010101_101010_111111});
        chk("t2_second", got_q[1], {2'b01, 96'h020202_030303_121212_131313});
        chk("t2_fourth", got_q[3], {2'b01, 96'h222222_232323_323232_333333});
        push_frame();
        check_stream("t2");

        // Test 3: output stall holds the window and blocks the next bottom-right pixel.
        ifc.m_ready = 1'b0;
        push_frame();
        for (int c = 0; c < H; c++) send_px(0, c, (c == 0));
        send_px(1, 0, 1'b0);
        send_px(1, 1, 1'b0);
        send_px(1, 2, 1'b0);
        @(negedge clk);
        ifc.s_pixel = px(1, 3);
        ifc.s_valid = 1'b1;
        ifc.s_sof   = 1'b0;
        #1;
        chk("t3_s_ready_low", W'(ifc.s_ready), W'(0));
        chk("t3_hold_win", W'({ifc.m_sof, ifc.m_eol, ifc.m_win}), {2'b10, 96'h000000_010101_101010_111111});
        repeat (3) @(negedge clk);
        #1;
        chk("t3_hold_win_late", W'(ifc.m_win), W'(96'h000000_010101_101010_111111));
        chk("t3_still_valid", W'(ifc.m_valid), W'(1));
        @(negedge clk);
        ifc.m_ready = 1'b1;
        #1;
        chk("t3_s_ready_high", W'(ifc.s_ready), W'(1));
        @(posedge clk);
        #1;
        chk("t3_backtoback", W'({ifc.m_valid, ifc.m_eol, ifc.m_win}), {2'b11, 96'h020202_030303_121212_131313});
        for (int r = 2; r < V; r++)
            for (int c = 0; c < H; c++) send_px(r, c, 1'b0);
        drain();
        check_stream("t3");

        // Test 4: s_sof after three pixels of row 0 resynchronises the frame.
        send_raw(24'hE0E0E0, 1'b1);
        send_raw(24'hE1E1E1, 1'b0);
        send_raw(24'hE2E2E2, 1'b0);
        chk("t4_no_err_yet", W'(ifc.sof_err), W'(0));
        send_px(0, 0, 1'b1);
        chk("t4_err_pulse", W'(ifc.sof_err), W'(1));
        send_px(0, 1, 1'b0);
        chk("t4_err_cleared", W'(ifc.sof_err), W'(0));
        for (int c = 2; c < H; c++) send_px(0, c, 1'b0);
        for (int r = 1; r < V; r++)
            for (int c = 0; c < H; c++) send_px(r, c, 1'b0);
        drain();
        push_frame();
        check_stream("t4");

        // Test 5: two frames with no idle between them.
        push_frame();
        push_frame();
        send_frame();
        send_frame();
        drain();
        check_stream("t5");

        // Test 6: random source gaps and sink stalls over three frames.
        rand_mode = 1'b1;
        for (int f = 0; f < 3; f++) begin
            push_frame();
            send_frame();
        end
        drain();
        check_stream("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
